// File: rtl/mmu_seq_pkg.sv
// Shared opcodes, FSM states and pipeline latencies for the MMU sequencer.
package mmu_seq_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_FP16 = 8'h03;
    localparam logic [7:0] OP_INT8 = 8'h04;

    localparam int unsigned MEM_LAT    = 1;
    localparam int unsigned MMU_LAT    = 1;
    localparam int unsigned PIPE_DEPTH = MEM_LAT + MMU_LAT;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_e;

    function automatic logic op_legal(input logic [7:0] op);
        return (op == OP_FP16) || (op == OP_INT8);
    endfunction

endpackage

// File: rtl/mmu_seq_acc.sv
// Tracks in-flight operand reads and accumulates the MMU's per-word partial sums.
module mmu_seq_acc
    import mmu_seq_pkg::*;
#(
    parameter int unsigned ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             issue,
    input  logic             sign_ext,
    input  logic [31:0]      mmu_result,
    output logic [ACC_W-1:0] acc,
    output logic             pending
);

    logic [PIPE_DEPTH-1:0] vld_q;
    logic [ACC_W-1:0]      ext;

    always_comb begin
        ext = sign_ext ? ACC_W'($signed(mmu_result)) : ACC_W'(mmu_result);
    end

    // The oldest valid bit lines up with the cycle mmu_result belongs to that read.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            acc   <= '0;
        end else begin
            vld_q <= {vld_q[PIPE_DEPTH-2:0], issue};
            if (clear) begin
                acc <= '0;
            end else if (vld_q[PIPE_DEPTH-1]) begin
                acc <= acc + ext;
            end
        end
    end

    assign pending = |vld_q;

endmodule

// File: rtl/mmu_seq_ctrl.sv
// Matrix-vector sequencer: issues A/B reads, feeds the MMU, emits one result per row.
// Optional perf counters are enabled with `define MMU_SEQ_PERF_EN.
module mmu_seq_ctrl
    import mmu_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 8,
    parameter int unsigned ACC_W  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        cmd_opcode,
    input  logic [ADDR_W-1:0] cmd_a_base,
    input  logic [ADDR_W-1:0] cmd_b_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [LEN_W-1:0]  cmd_count,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    input  logic [31:0]       a_rd_data,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_rd_addr,
    input  logic [31:0]       b_rd_data,
    output logic [7:0]        mmu_opcode,
    output logic [31:0]       mmu_a,
    output logic [31:0]       mmu_b,
    input  logic [31:0]       mmu_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_last,
    output logic              busy,
`ifdef MMU_SEQ_PERF_EN
    output logic              err_opcode,
    output logic [31:0]       perf_active_cycles,
    output logic [31:0]       perf_stall_cycles
`else
    output logic              err_opcode
`endif
);

    state_e            state_q;
    logic [7:0]        op_q;
    logic [ADDR_W-1:0] b_base_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count_q;
    logic [LEN_W-1:0]  row_q;
    logic [LEN_W-1:0]  word_q;

    logic              accept;
    logic              start_cmd;
    logic              next_row;
    logic              acc_clear;
    logic [ACC_W-1:0]  acc;
    logic              pending;
    logic [ADDR_W-1:0] next_row_base;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mmu_a     = a_rd_data;
    assign mmu_b     = b_rd_data;

    assign accept        = cmd_valid && cmd_ready;
    assign start_cmd     = accept && op_legal(cmd_opcode) && (cmd_count != '0);
    assign next_row      = (state_q == OUT) && res_ready && !res_last;
    assign acc_clear     = start_cmd || next_row;
    assign next_row_base = row_base_q + ADDR_W'(len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= OP_NOP;
            b_base_q   <= '0;
            row_base_q <= '0;
            len_q      <= '0;
            count_q    <= '0;
            row_q      <= '0;
            word_q     <= '0;
            a_rd_en    <= 1'b0;
            b_rd_en    <= 1'b0;
            a_rd_addr  <= '0;
            b_rd_addr  <= '0;
            mmu_opcode <= OP_NOP;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_last   <= 1'b0;
            err_opcode <= 1'b0;
        end else begin
            err_opcode <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q       <= cmd_opcode;
                        b_base_q   <= cmd_b_base;
                        row_base_q <= cmd_a_base;
                        len_q      <= cmd_len;
                        count_q    <= cmd_count;
                        if (!op_legal(cmd_opcode)) begin
                            err_opcode <= 1'b1;
                        end else if (cmd_count != '0) begin
                            state_q    <= ISSUE;
                            row_q      <= '0;
                            word_q     <= '0;
                            a_rd_en    <= (cmd_len != '0);
                            b_rd_en    <= (cmd_len != '0);
                            a_rd_addr  <= cmd_a_base;
                            b_rd_addr  <= cmd_b_base;
                            mmu_opcode <= cmd_opcode;
                        end
                    end
                end
                ISSUE: begin
                    if ((len_q == '0) || (word_q == len_q - LEN_W'(1))) begin
                        state_q <= DRAIN;
                        a_rd_en <= 1'b0;
                        b_rd_en <= 1'b0;
                    end else begin
                        word_q    <= word_q + LEN_W'(1);
                        a_rd_addr <= a_rd_addr + ADDR_W'(1);
                        b_rd_addr <= b_rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    if (!pending) begin
                        state_q    <= OUT;
                        res_valid  <= 1'b1;
                        res_data   <= acc;
                        res_last   <= (row_q == count_q - LEN_W'(1));
                        mmu_opcode <= OP_NOP;
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_last  <= 1'b0;
                        if (res_last) begin
                            state_q <= IDLE;
                        end else begin
                            state_q    <= ISSUE;
                            row_q      <= row_q + LEN_W'(1);
                            word_q     <= '0;
                            row_base_q <= next_row_base;
                            a_rd_addr  <= next_row_base;
                            b_rd_addr  <= b_base_q;
                            a_rd_en    <= (len_q != '0);
                            b_rd_en    <= (len_q != '0);
                            mmu_opcode <= op_q;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mmu_seq_acc #(
        .ACC_W(ACC_W)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clear     (acc_clear),
        .issue     (a_rd_en),
        .sign_ext  (op_q == OP_INT8),
        .mmu_result(mmu_result),
        .acc       (acc),
        .pending   (pending)
    );

`ifdef MMU_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_active_cycles <= '0;
            perf_stall_cycles  <= '0;
        end else begin
            if (((state_q == ISSUE) || (state_q == DRAIN)) && (perf_active_cycles != '1)) begin
                perf_active_cycles <= perf_active_cycles + 32'd1;
            end
            if ((state_q == OUT) && !res_ready && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mmu_seq_ctrl.sv
// Scoreboard bench for mmu_seq_ctrl with behavioural operand SRAM and MMU models.
module tb_mmu_seq_ctrl;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 8;
    localparam int ACC_W  = 40;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [7:0]        cmd_opcode = '0;
    logic [ADDR_W-1:0] cmd_a_base = '0;
    logic [ADDR_W-1:0] cmd_b_base = '0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [LEN_W-1:0]  cmd_count = '0;
    logic              a_rd_en, b_rd_en;
    logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
    logic [31:0]       a_rd_data = '0;
    logic [31:0]       b_rd_data = '0;
    logic [7:0]        mmu_opcode;
    logic [31:0]       mmu_a, mmu_b;
    logic [31:0]       mmu_result = '0;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic [ACC_W-1:0]  res_data;
    logic              res_last;
    logic              busy;
    logic              err_opcode;
`ifdef MMU_SEQ_PERF_EN
    logic [31:0]       perf_active, perf_stall;
`endif

    mmu_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_a_base(cmd_a_base),
        .cmd_b_base(cmd_b_base),
        .cmd_len   (cmd_len),
        .cmd_count (cmd_count),
        .a_rd_en   (a_rd_en),
        .a_rd_addr (a_rd_addr),
        .a_rd_data (a_rd_data),
        .b_rd_en   (b_rd_en),
        .b_rd_addr (b_rd_addr),
        .b_rd_data (b_rd_data),
        .mmu_opcode(mmu_opcode),
        .mmu_a     (mmu_a),
        .mmu_b     (mmu_b),
        .mmu_result(mmu_result),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_last  (res_last),
        .busy      (busy),
`ifdef MMU_SEQ_PERF_EN
        .err_opcode(err_opcode),
        .perf_active_cycles(perf_active),
        .perf_stall_cycles (perf_stall)
`else
        .err_opcode(err_opcode)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ACC_W-1:0] data;
        logic             last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mem_a [DEPTH];
    logic [31:0] mem_b [DEPTH];
    int          tests = 0;
    int          fails = 0;
    int          err_cnt = 0;
    bit          rand_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [ACC_W-1:0] prev_data = '0;
    logic        prev_last = 1'b0;

    // MMU behaviour: INT8 = signed byte dot product, FP16 path = halfword products summed.
    function automatic logic [31:0] mmu_fn(input logic [7:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        int s;
        int x;
        int y;
        s = 0;
        if (op == 8'h04) begin
            for (int i = 0; i < 4; i++) begin
                x = int'($signed(a[8*i +: 8]));
                y = int'($signed(b[8*i +: 8]));
                s += x * y;
            end
            return 32'(s);
        end else if (op == 8'h03) begin
            return 32'(a[31:16]) * 32'(b[31:16]) + 32'(a[15:0]) * 32'(b[15:0]);
        end
        return 32'd0;
    endfunction

    function automatic logic [ACC_W-1:0] ref_row(input logic [7:0] op, input int ab,
                                                 input int bb, input int len, input int r);
        logic [ACC_W-1:0] sum;
        logic [31:0]      m;
        sum = '0;
        for (int w = 0; w < len; w++) begin
            m = mmu_fn(op, mem_a[(ab + r * len + w) % DEPTH], mem_b[(bb + w) % DEPTH]);
            if (op == 8'h04) sum += {{(ACC_W-32){m[31]}}, m};
            else             sum += {{(ACC_W-32){1'b0}}, m};
        end
        return sum;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [ACC_W-1:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = $urandom();
            mem_b[i] = $urandom();
        end
    endtask

    task automatic send_cmd(input logic [7:0] op, input int ab, input int bb, input int len,
                            input int cnt, input bit auto_exp);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        if (auto_exp && (op == 8'h03 || op == 8'h04)) begin
            for (int r = 0; r < cnt; r++) push_exp(ref_row(op, ab, bb, len, r), r == cnt - 1);
        end
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a_base = ADDR_W'(ab);
        cmd_b_base = ADDR_W'(bb);
        cmd_len    = LEN_W'(len);
        cmd_count  = LEN_W'(cnt);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while ((busy || exp_q.size() != 0) && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 3000) begin
            check("done_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic wait_res_valid();
        int guard;
        guard = 0;
        while (!res_valid && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!res_valid) check("res_valid_timeout", 64'(res_valid), 64'd1);
    endtask

    // Operand SRAMs (1-cycle read) and registered MMU; idle read data is garbage on purpose.
    always @(posedge clk) begin
        a_rd_data  <= a_rd_en ? mem_a[a_rd_addr] : $urandom();
        b_rd_data  <= b_rd_en ? mem_b[b_rd_addr] : $urandom();
        mmu_result <= mmu_fn(mmu_opcode, mmu_a, mmu_b);
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            res_ready = ($urandom_range(0, 1) == 1);
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_stable", 64'({res_valid, res_last, res_data}),
                      64'({1'b1, prev_last, prev_data}));
            end
            if (res_valid) check("no_read_in_out", 64'({a_rd_en, b_rd_en}), 64'd0);
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got %0h last=%0b, expected none",
                             res_data, res_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("row_result", 64'({res_last, res_data}), 64'({mon_e.last, mon_e.data}));
                end
            end
            if (err_opcode) err_cnt++;
            prev_stall = res_valid && !res_ready;
            prev_data  = res_data;
            prev_last  = res_last;
        end
    end

    initial begin
        int n;
        int errs0;
        bit bad;
        logic [ACC_W-1:0] held;

        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", 64'({cmd_ready, busy, a_rd_en, b_rd_en, res_valid, res_last,
                                 err_opcode}), 64'b1000000);
        check("reset_data", 64'({a_rd_addr, b_rd_addr, mmu_opcode}), 64'd0);
        check("reset_res_data", 64'(res_data), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // INT8 len=2: 1+2+3+4 per word.
        for (int i = 0; i < 2; i++) begin
            mem_a[10 + i] = 32'h01020304;
            mem_b[100 + i] = 32'h01010101;
        end
        push_exp(40'd20, 1'b1);
        send_cmd(8'h04, 10, 100, 2, 1, 1'b0);
        n = 0;
        while (!res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("first_latency", 64'(n), 64'd5);
        wait_done();

        // INT8 negative sum: 3 words of -8.
        for (int i = 0; i < 3; i++) begin
            mem_a[20 + i] = 32'hFFFFFFFF;
            mem_b[200 + i] = 32'h02020202;
        end
        push_exp(40'hFFFFFFFFE8, 1'b1);
        send_cmd(8'h04, 20, 200, 3, 1, 1'b0);
        wait_done();

        // FP16 path, two rows, zero-extended.
        mem_a[30]  = 32'h00020003;
        mem_a[31]  = 32'h00010001;
        mem_b[300] = 32'h00040005;
        push_exp(40'd23, 1'b0);
        push_exp(40'd9, 1'b1);
        send_cmd(8'h03, 30, 300, 1, 2, 1'b0);
        wait_done();

        // Backpressure for 10 cycles on row 0.
        randomize_mem();
        res_ready = 1'b0;
        send_cmd(8'h04, 40, 400, 2, 3, 1'b1);
        wait_res_valid();
        held = res_data;
        bad = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (a_rd_en || b_rd_en || !res_valid || res_data !== held) bad = 1'b1;
        end
        check("bp_hold_no_reads", 64'(bad), 64'd0);
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_next_row_start", 64'({a_rd_en, a_rd_addr}), 64'({1'b1, 10'd42}));
        wait_done();

        // Illegal opcode.
        errs0 = err_cnt;
        send_cmd(8'h07, 50, 500, 2, 2, 1'b1);
        check("err_pulse", 64'(err_opcode), 64'd1);
        bad = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (a_rd_en || b_rd_en || res_valid || busy || err_opcode) bad = 1'b1;
        end
        check("illegal_quiet", 64'(bad), 64'd0);
        check("err_pulse_count", 64'(err_cnt - errs0), 64'd1);

        // count=0 is accepted and produces nothing.
        send_cmd(8'h04, 60, 600, 3, 0, 1'b1);
        check("count0_ready", 64'({cmd_ready, busy}), 64'b10);
        bad = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (a_rd_en || res_valid || busy) bad = 1'b1;
        end
        check("count0_quiet", 64'(bad), 64'd0);

        // Reset during row 1 issue, then a clean command.
        randomize_mem();
        send_cmd(8'h04, 70, 700, 6, 3, 1'b1);
        wait_res_valid();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_issuing", 64'(a_rd_en), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_idle", 64'({cmd_ready, busy, a_rd_en, b_rd_en, res_valid, err_opcode}),
              64'b100000);
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        randomize_mem();
        send_cmd(8'h04, 70, 700, 6, 2, 1'b1);
        wait_done();

        // Randomized commands with random backpressure.
        for (int t = 0; t < 25; t++) begin
            randomize_mem();
            rand_ready = 1'b1;
            send_cmd(($urandom_range(0, 1) == 1) ? 8'h04 : 8'h03, int'($urandom_range(0, DEPTH - 1)),
                     int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 7)),
                     int'($urandom_range(1, 4)), 1'b1);
            wait_done();
            rand_ready = 1'b0;
            #2;
            res_ready = 1'b1;
            @(posedge clk); #1;
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
